// File: rtl/apb_initiator_if.sv
// Request/response channels and APB initiator port of apb_initiator.
// master: the initiator's view; slave: the view of whatever drives requests and models the APB target.
interface apb_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic [2:0]  req_prot;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic [31:0] out_paddr;
  logic        out_psel;
  logic        out_penable;
  logic [2:0]  out_pprot;
  logic        out_pwrite;
  logic [31:0] out_pwdata;
  logic [3:0]  out_pstrb;
  logic        out_pready;
  logic [31:0] out_prdata;
  logic        out_pslverr;

  modport master (
    input  req_valid, req_addr, req_write, req_wdata, req_wstrb, req_prot,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output out_paddr, out_psel, out_penable, out_pprot, out_pwrite, out_pwdata, out_pstrb,
    input  out_pready, out_prdata, out_pslverr
  );

  modport slave (
    output req_valid, req_addr, req_write, req_wdata, req_wstrb, req_prot,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  out_paddr, out_psel, out_penable, out_pprot, out_pwrite, out_pwdata, out_pstrb,
    output out_pready, out_prdata, out_pslverr
  );
endinterface

// File: rtl/apb_initiator.sv
// Single-outstanding APB initiator: request -> SETUP -> ACCESS (wait/timeout) -> held response.
module apb_initiator #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clock,
  input  logic             reset,
  apb_initiator_if.master  bus
);

  localparam int unsigned      CW  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]    TMO = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e        state_q;
  logic [CW-1:0] wait_q;
  logic [31:0]   paddr_q;
  logic          pwrite_q;
  logic [2:0]    pprot_q;
  logic [31:0]   pwdata_q;
  logic [3:0]    pstrb_q;
  logic          psel_q;
  logic          penable_q;
  logic          rsp_valid_q;
  logic [31:0]   rsp_rdata_q;
  logic          rsp_err_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pprot_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            paddr_q  <= bus.req_addr;
            pwrite_q <= bus.req_write;
            pprot_q  <= bus.req_prot;
            pwdata_q <= bus.req_wdata;
            pstrb_q  <= bus.req_write ? bus.req_wstrb : 4'b0000;
            psel_q   <= 1'b1;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          wait_q    <= '0;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          // A ready slave beats a coincident timeout.
          if (bus.out_pready) begin
            rsp_rdata_q <= pwrite_q ? '0 : bus.out_prdata;
            rsp_err_q   <= bus.out_pslverr;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if ((TIMEOUT != 0) && (wait_q == TMO)) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (wait_q != '1) begin
            wait_q <= wait_q + CW'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.out_paddr   = paddr_q;
  assign bus.out_psel    = psel_q;
  assign bus.out_penable = penable_q;
  assign bus.out_pprot   = pprot_q;
  assign bus.out_pwrite  = pwrite_q;
  assign bus.out_pwdata  = pwdata_q;
  assign bus.out_pstrb   = pstrb_q;

endmodule

// File: tb/tb_apb_initiator.sv
// Bench for apb_initiator: transaction-level model predicts bus phases and responses each cycle,
// a reactive APB target supplies per-transfer wait states, and literal pins check the logged results.
module tb_apb_initiator;

  localparam int TMO = 4;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  apb_initiator_if bus ();

  apb_initiator #(.TIMEOUT(TMO)) dut (
    .clock (clock),
    .reset (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [2:0]  prot;
    int          waits;   // ACCESS cycles before pready; >=255 means never
    logic [31:0] prdata;
    logic        slverr;
  } txn_t;

  // Target behaviour for the request currently on the request channel.
  int          sl_waits;
  logic [31:0] sl_rdata;
  logic        sl_err;

  // Model state
  bit          busy = 1'b0;
  int          t;
  int          len;
  logic [31:0] e_rdata;
  logic        e_err;
  txn_t        cur;
  int          acc_k, pen_cnt, rv_cnt, first_lat;

  int          n_done = 0;
  logic [31:0] lg_rdata [16];
  logic        lg_err   [16];
  int          lg_pen   [16];
  int          lg_rv    [16];
  int          lg_lat   [16];

  // Compare process and reactive APB target.
  always @(negedge clock) begin
    if (!rst_n) begin
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_psel", 32'(bus.out_psel), 32'd0);
      chk("rst_penable", 32'(bus.out_penable), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      busy = 1'b0;
    end else begin
      chk("req_ready", 32'(bus.req_ready), 32'(!busy));
      if (!busy) begin
        chk("idle_psel", 32'(bus.out_psel), 32'd0);
        chk("idle_penable", 32'(bus.out_penable), 32'd0);
        chk("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      end else begin
        chk("psel", 32'(bus.out_psel), 32'(t <= 1 + len));
        chk("penable", 32'(bus.out_penable), 32'(t >= 2 && t <= 1 + len));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(t >= 2 + len));
        if (bus.out_psel) begin
          chk("paddr", bus.out_paddr, cur.addr);
          chk("pwrite", 32'(bus.out_pwrite), 32'(cur.wr));
          chk("pwdata", bus.out_pwdata, cur.wdata);
          chk("pstrb", 32'(bus.out_pstrb), cur.wr ? 32'(cur.wstrb) : 32'd0);
          chk("pprot", 32'(bus.out_pprot), 32'(cur.prot));
        end
        if (bus.out_penable) pen_cnt++;
        if (bus.rsp_valid) begin
          if (rv_cnt == 0) first_lat = t;
          rv_cnt++;
          chk("rsp_rdata", bus.rsp_rdata, e_rdata);
          chk("rsp_err", 32'(bus.rsp_err), 32'(e_err));
        end
      end
    end

    // Target: meaningful values only in ACCESS, deliberate garbage elsewhere.
    if (rst_n && busy && bus.out_psel && bus.out_penable) begin
      bus.out_pready  = (acc_k == cur.waits);
      bus.out_prdata  = cur.prdata;
      bus.out_pslverr = cur.slverr;
      acc_k++;
    end else begin
      bus.out_pready  = 1'b1;
      bus.out_prdata  = 32'hBAD0_0BAD;
      bus.out_pslverr = 1'b1;
    end

    // Predict the coming edge.
    if (rst_n) begin
      if (busy) begin
        if (t >= 2 + len && bus.rsp_ready) begin
          if (n_done < 16) begin
            lg_rdata[n_done] = bus.rsp_rdata;
            lg_err[n_done]   = bus.rsp_err;
            lg_pen[n_done]   = pen_cnt;
            lg_rv[n_done]    = rv_cnt;
            lg_lat[n_done]   = first_lat;
          end
          n_done++;
          busy = 1'b0;
        end else begin
          t++;
        end
      end else if (bus.req_valid) begin
        cur.addr   = bus.req_addr;
        cur.wr     = bus.req_write;
        cur.wdata  = bus.req_wdata;
        cur.wstrb  = bus.req_wstrb;
        cur.prot   = bus.req_prot;
        cur.waits  = sl_waits;
        cur.prdata = sl_rdata;
        cur.slverr = sl_err;
        if (TMO > 0 && cur.waits > TMO) begin
          len = TMO + 1; e_err = 1'b1; e_rdata = '0;
        end else begin
          len = cur.waits + 1; e_err = cur.slverr; e_rdata = cur.wr ? 32'd0 : cur.prdata;
        end
        busy = 1'b1; t = 1; acc_k = 0; pen_cnt = 0; rv_cnt = 0; first_lat = 0;
      end
    end
  end

  // Caller is at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic issue(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic [2:0] prot, input int waits,
                       input logic [31:0] prdata, input logic slverr, input bit keep_valid);
    bit ok = 1'b0;
    bus.req_addr = addr; bus.req_write = wr; bus.req_wdata = wdata;
    bus.req_wstrb = wstrb; bus.req_prot = prot;
    sl_waits = waits; sl_rdata = prdata; sl_err = slverr;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (bus.req_ready) begin ok = 1'b1; break; end
    end
    chk("accept_within_budget", 32'(ok), 32'd1);
    @(posedge clock); #1;
    if (!keep_valid) bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #1;
      if (!busy) begin ok = 1'b1; break; end
    end
    chk("idle_within_budget", 32'(ok), 32'd1);
  endtask

  initial begin
    bit seen;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_write = 1'b0; bus.req_wdata = '0;
    bus.req_wstrb = '0; bus.req_prot = '0; bus.rsp_ready = 1'b1;
    bus.out_pready = 1'b0; bus.out_prdata = '0; bus.out_pslverr = 1'b0;
    sl_waits = 0; sl_rdata = '0; sl_err = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("reset_paddr", bus.out_paddr, 32'd0);
    rst_n = 1'b1;

    // 0: zero-wait read
    issue(32'h1000_0004, 1'b0, 32'h1234_5678, 4'hF, 3'b010, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    wait_idle();
    // 1: write, 3 wait states
    issue(32'h1000_0000, 1'b1, 32'h0000_F0F0, 4'h3, 3'b001, 3, 32'h5555_AAAA, 1'b0, 1'b0);
    wait_idle();
    // 2: slave error, response held 5 cycles
    bus.rsp_ready = 1'b0;
    issue(32'h2000_0008, 1'b0, 32'h0, 4'h0, 3'b000, 1, 32'h0BAD_F00D, 1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.rsp_valid) begin seen = 1'b1; break; end
    end
    chk("rsp_seen_within_budget", 32'(seen), 32'd1);
    repeat (4) @(negedge clock);
    @(posedge clock); #1;
    bus.rsp_ready = 1'b1;
    wait_idle();
    // 3: timeout, pready stuck low
    issue(32'h3000_0000, 1'b1, 32'hCAFE_BABE, 4'hC, 3'b111, 255, 32'h1111_1111, 1'b0, 1'b0);
    wait_idle();
    // 4: pready on the 5th ACCESS cycle
    issue(32'h3000_0004, 1'b0, 32'h0, 4'hF, 3'b011, 4, 32'h600D_CAFE, 1'b0, 1'b0);
    wait_idle();

    // Reset mid-ACCESS
    issue(32'h5000_0000, 1'b0, 32'h0, 4'hF, 3'b000, 3, 32'h7777_7777, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.out_penable) begin seen = 1'b1; break; end
    end
    chk("access_seen_within_budget", 32'(seen), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_psel", 32'(bus.out_psel), 32'd0);
    chk("async_penable", 32'(bus.out_penable), 32'd0);
    chk("async_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("async_req_ready", 32'(bus.req_ready), 32'd1);
    repeat (2) @(posedge clock);
    #1 rst_n = 1'b1;
    // 5: read after reset
    issue(32'h4000_0010, 1'b0, 32'h0, 4'h5, 3'b100, 0, 32'h1357_9BDF, 1'b0, 1'b0);
    wait_idle();

    // 6..8: back-to-back with req_valid held
    issue(32'h6000_0000, 1'b0, 32'h0, 4'hF, 3'b000, 0, 32'hA0A0_0001, 1'b0, 1'b1);
    issue(32'h6000_0004, 1'b1, 32'hB0B0_0002, 4'h6, 3'b001, 1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    issue(32'h6000_0008, 1'b0, 32'h0, 4'h0, 3'b010, 2, 32'hC0C0_0003, 1'b0, 1'b0);
    wait_idle();

    // Literal pins on the logged responses
    chk("n_done", 32'(n_done), 32'd9);
    chk("t0_rdata", lg_rdata[0], 32'hDEAD_BEEF);
    chk("t0_err", 32'(lg_err[0]), 32'd0);
    chk("t0_latency", 32'(lg_lat[0]), 32'd3);
    chk("t0_access_cycles", 32'(lg_pen[0]), 32'd1);
    chk("t1_access_cycles", 32'(lg_pen[1]), 32'd4);
    chk("t1_rdata", lg_rdata[1], 32'd0);
    chk("t1_err", 32'(lg_err[1]), 32'd0);
    chk("t2_err", 32'(lg_err[2]), 32'd1);
    chk("t2_rdata", lg_rdata[2], 32'h0BAD_F00D);
    chk("t2_rsp_cycles", 32'(lg_rv[2]), 32'd6);
    chk("t3_access_cycles", 32'(lg_pen[3]), 32'd5);
    chk("t3_err", 32'(lg_err[3]), 32'd1);
    chk("t3_rdata", lg_rdata[3], 32'd0);
    chk("t4_access_cycles", 32'(lg_pen[4]), 32'd5);
    chk("t4_err", 32'(lg_err[4]), 32'd0);
    chk("t4_rdata", lg_rdata[4], 32'h600D_CAFE);
    chk("t5_rdata", lg_rdata[5], 32'h1357_9BDF);
    chk("t6_rdata", lg_rdata[6], 32'hA0A0_0001);
    chk("t7_rdata", lg_rdata[7], 32'd0);
    chk("t8_rdata", lg_rdata[8], 32'hC0C0_0003);
    chk("t8_access_cycles", 32'(lg_pen[8]), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/apb_initiator.md
APB_INITIATOR -- requirements
Module: apb_initiator

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 255, ACCESS-phase cycles without out_pready before forced error completion; 0 disables timeout.
REQ-002 SHALL provide port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 SHALL provide req_valid  input  1  request present.
REQ-005 SHALL provide req_ready  output  1  request accepted when valid&ready.
REQ-006 SHALL provide req_addr  input  32, req_write  input  1, req_wdata  input  32, req_wstrb  input  4, req_prot  input  3  (transfer attributes).
REQ-007 SHALL provide rsp_valid  output  1, rsp_ready  input  1, rsp_rdata  output  32, rsp_err  output  1  (response channel).
REQ-008 SHALL provide APB initiator port: out_paddr  output  32, out_psel  output  1, out_penable  output  1, out_pprot  output  3, out_pwrite  output  1, out_pwdata  output  32, out_pstrb  output  4, out_pready  input  1, out_prdata  input  32, out_pslverr  input  1.

Function
REQ-009 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP; one transfer outstanding at most.
REQ-010 SHALL assert req_ready only in IDLE; req_ready combinational from state only, never from req_valid.
REQ-011 IDLE -> SETUP on req_valid&req_ready; all req_* fields latched that edge.
REQ-012 SETUP: out_psel=1, out_penable=0; exactly one cycle; -> ACCESS unconditionally.
REQ-013 ACCESS: out_psel=1, out_penable=1; held until out_pready=1 or timeout.
REQ-014 out_paddr, out_pwrite, out_pprot, out_pwdata, out_pstrb SHALL be registered and stable from SETUP through final ACCESS cycle.
REQ-015 Read (req_write=0): out_pstrb SHALL be 4'b0000 regardless of req_wstrb; out_pwdata = latched req_wdata.
REQ-016 ACCESS with out_pready=1: sample out_prdata (reads; writes capture 0) into rsp_rdata and out_pslverr into rsp_err; -> RESP next edge; out_psel, out_penable 0 next cycle.
REQ-017 Minimum latency: accept edge N, SETUP cycle N+1, ACCESS cycle N+2, rsp_valid=1 in cycle N+3 when out_pready=1 in first ACCESS cycle.
REQ-018 Wait counter SHALL clear on entering ACCESS, increment each ACCESS cycle with out_pready=0; saturating, width ceil(log2(TIMEOUT+1)) min 1.
REQ-019 TIMEOUT>0 and counter==TIMEOUT with out_pready=0: -> RESP with rsp_err=1, rsp_rdata=0; psel/penable deassert next cycle.
REQ-020 out_pready=1 in the same cycle as timeout: normal completion (REQ-016) wins.
REQ-021 RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_valid&rsp_ready; then -> IDLE.
REQ-022 rsp_ready ignored outside RESP; out_pready/out_prdata/out_pslverr ignored outside ACCESS.
REQ-023 No back-to-back bypass: after RESP handshake, at least one IDLE cycle precedes next SETUP.

Reset
REQ-024 reset=0 SHALL asynchronously force state IDLE, counter 0, and all outputs 0 except req_ready=1 once IDLE is taken (i.e. req_ready=1 during reset).
REQ-025 reset asserted mid-transfer (SETUP/ACCESS/RESP) SHALL abort it: out_psel, out_penable, rsp_valid drop to 0 immediately without waiting for clock; no response issued for aborted transfer.
REQ-026 Deassertion of reset SHALL take effect synchronously; first acceptance possible on first rising edge after reset=1.

Verification
REQ-027 Read, zero-wait: req addr=0x1000_0004, write=0, wstrb=4'hF; slave pready=1 first ACCESS, prdata=0xDEAD_BEEF -> out_pstrb=0, rsp_valid cycle N+3, rsp_rdata=0xDEAD_BEEF, rsp_err=0.
REQ-028 Write, 3 wait states: addr=0x1000_0000, wdata=0x0000_F0F0, wstrb=4'h3 -> psel=1,penable=1 for 4 cycles, paddr/pwdata/pstrb stable throughout, rsp_rdata=0, rsp_err=0.
REQ-029 Slave error: pslverr=1 with pready=1 -> rsp_err=1; rsp held 5 cycles with rsp_ready=0, values unchanged, then one-cycle handshake returns to IDLE.
REQ-030 Timeout, TIMEOUT=4: pready stuck 0 -> ACCESS lasts 5 cycles, rsp_err=1, rsp_rdata=0; repeat with pready=1 on 5th ACCESS cycle -> normal completion, rsp_err=0.
REQ-031 Reset mid-ACCESS: drive reset=0 between edges -> psel, penable 0 same cycle; after release, new read completes with correct data and no stale response.
REQ-032 Back-to-back: req_valid held high for 3 requests -> req_ready only in IDLE, each transfer gets separate SETUP, responses in order.
